// File: rtl/eq_gain_sequencer_pkg.sv
// Shared constants and types for the equalizer gain path (sequencer and register map).
package eq_pkg;

   localparam int unsigned NUM_BANDS      = 10;
   localparam int unsigned IDX_WIDTH      = 8;
   localparam int unsigned MAX_IDX        = 34;
   localparam int unsigned DEFAULT_IDX    = 17;
   localparam int unsigned REG_ADDR_WIDTH = 8;
   localparam int unsigned BAND_WIDTH     = 4;

   typedef logic [IDX_WIDTH-1:0]      idx_t;
   typedef logic [BAND_WIDTH-1:0]     band_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   typedef enum logic [1:0] {INIT, IDLE, SWEEP} eq_state_t;

   localparam band_t LAST_BAND  = band_t'(NUM_BANDS - 1);
   localparam band_t BAND_LIMIT = band_t'(NUM_BANDS);
   localparam idx_t  MAX_IDX_V  = idx_t'(MAX_IDX);
   localparam idx_t  DEF_IDX_V  = idx_t'(DEFAULT_IDX);

   // Out-of-range host requests saturate rather than being rejected.
   function automatic idx_t clamp_idx(idx_t v);
      return (v > MAX_IDX_V) ? MAX_IDX_V : v;
   endfunction

endpackage

// File: rtl/eq_gain_sequencer_if.sv
// Host target-update handshake between the control interface and the gain sequencer.
interface eq_gain_sequencer_if;

   logic            host_valid;
   logic            host_ready;
   eq_pkg::band_t   host_band;
   eq_pkg::idx_t    host_idx;

   modport master (output host_valid, output host_band, output host_idx, input host_ready);
   modport slave  (input host_valid, input host_band, input host_idx, output host_ready);

endinterface

// File: rtl/eq_gain_sequencer_stepper.sv
// Next programmed gain index for one band. GAIN_RAMP_EN selects +/-1 slewing;
// without it the band jumps straight to its target.
module eq_idx_stepper
   import eq_pkg::*;
(
   input  idx_t cur,
   input  idx_t tgt,
   output idx_t next_idx
);

`ifdef GAIN_RAMP_EN
   always_comb begin
      next_idx = cur;
      if (cur < tgt)
         next_idx = cur + idx_t'(1);
      else if (cur > tgt)
         next_idx = cur - idx_t'(1);
   end
`else
   assign next_idx = tgt;
`endif

endmodule

// File: rtl/eq_gain_sequencer.sv
// Owns the gain register-map write port: initialises all bands, then sweeps them toward
// host targets once per tick. Optional slewing via macro GAIN_RAMP_EN (see eq_idx_stepper).
module eq_gain_sequencer
   import eq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   eq_gain_sequencer_if.slave   host,
   input  logic                 tick,
   input  logic                 ovr_clr,
   output logic                 we,
   output reg_addr_t            addr,
   output idx_t                 data_in,
   output logic                 busy,
   output logic                 err,
   output logic                 overrun
);

   eq_state_t state;
   band_t     ptr;
   idx_t      tgt [NUM_BANDS];
   idx_t      cur [NUM_BANDS];
   idx_t      cur_p;
   idx_t      tgt_p;
   idx_t      next_idx;

   assign cur_p = cur[ptr];
   assign tgt_p = tgt[ptr];

   eq_idx_stepper u_stepper (
      .cur      (cur_p),
      .tgt      (tgt_p),
      .next_idx (next_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= INIT;
         ptr             <= '0;
         we              <= 1'b0;
         addr            <= '0;
         data_in         <= '0;
         busy            <= 1'b1;
         err             <= 1'b0;
         overrun         <= 1'b0;
         host.host_ready <= 1'b0;
         for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            tgt[i] <= DEF_IDX_V;
            cur[i] <= DEF_IDX_V;
         end
      end else begin
         we              <= 1'b0;
         err             <= 1'b0;
         // Status outputs track the state the current decision is made in.
         busy            <= (state != IDLE);
         host.host_ready <= (state != INIT);

         // Target lands one cycle after acceptance, so a band being swept this cycle uses the old target.
         if (host.host_valid && host.host_ready) begin
            if (host.host_band >= BAND_LIMIT)
               err <= 1'b1;
            else
               tgt[host.host_band] <= clamp_idx(host.host_idx);
         end

         if (tick && (state != IDLE))
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;

         case (state)
            INIT: begin
               we      <= 1'b1;
               addr    <= reg_addr_t'(ptr);
               data_in <= DEF_IDX_V;
               if (ptr == LAST_BAND) begin
                  ptr   <= '0;
                  state <= IDLE;
               end else begin
                  ptr <= ptr + band_t'(1);
               end
            end
            IDLE: begin
               if (tick) begin
                  ptr   <= '0;
                  state <= SWEEP;
               end
            end
            SWEEP: begin
               if (cur_p != tgt_p) begin
                  we       <= 1'b1;
                  addr     <= reg_addr_t'(ptr);
                  data_in  <= next_idx;
                  cur[ptr] <= next_idx;
               end
               if (ptr == LAST_BAND) begin
                  ptr   <= '0;
                  state <= IDLE;
               end else begin
                  ptr <= ptr + band_t'(1);
               end
            end
            default: begin
               ptr   <= '0;
               state <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Directed self-checking bench for eq_gain_sequencer; expectations follow GAIN_RAMP_EN.
module tb_eq_gain_sequencer;

`ifdef GAIN_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       tick;
   logic       ovr_clr;
   logic       we;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       busy;
   logic       err;
   logic       overrun;

   int tests = 0;
   int fails = 0;

   eq_gain_sequencer_if hif ();

   eq_gain_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .host    (hif),
      .tick    (tick),
      .ovr_clr (ovr_clr),
      .we      (we),
      .addr    (addr),
      .data_in (data_in),
      .busy    (busy),
      .err     (err),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic init_check();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("init_we", we, 1);
         chk("init_addr", addr, i);
         chk("init_data", data_in, 17);
         chk("init_busy", busy, 1);
         chk("init_ready", hif.host_ready, 0);
      end
      @(negedge clk);
      chk("post_init_we", we, 0);
      chk("post_init_busy", busy, 0);
      chk("post_init_ready", hif.host_ready, 1);
   endtask

   task automatic host_write(input int band, input int idx, output logic e);
      chk("ready_before_write", hif.host_ready, 1);
      hif.host_valid = 1'b1;
      hif.host_band  = 4'(band);
      hif.host_idx   = 8'(idx);
      @(negedge clk);
      e = err;
      hif.host_valid = 1'b0;
   endtask

   // One tick then the full sweep window; extra_at >= 0 injects a second tick mid-sweep.
   task automatic sweep(input int extra_at, output int n, output int la, output int ld);
      n  = 0;
      la = -1;
      ld = -1;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         if (we) begin
            n++;
            la = int'(addr);
            ld = int'(data_in);
         end
         tick = (j == extra_at);
      end
      tick = 1'b0;
   endtask

   initial begin
      int   n, la, ld, exp_n, exp_d, found;
      logic e;

      rst            = 1'b1;
      tick           = 1'b0;
      ovr_clr        = 1'b0;
      hif.host_valid = 1'b0;
      hif.host_band  = '0;
      hif.host_idx   = '0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data_in, 0);
      chk("rst_busy", busy, 1);
      chk("rst_err", err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ready", hif.host_ready, 0);
      rst = 1'b0;
      init_check();

      // Band 3 -> 20
      host_write(3, 20, e);
      chk("b3_err", e, 0);
      for (int k = 0; k < 4; k++) begin
         sweep(-1, n, la, ld);
         exp_n = RAMP ? int'(k < 3) : int'(k == 0);
         exp_d = RAMP ? 18 + k : 20;
         chk("b3_nwrites", n, exp_n);
         if (exp_n == 1) begin
            chk("b3_addr", la, 3);
            chk("b3_data", ld, exp_d);
         end
      end

      // Band 0 -> 40, clamped to 34
      host_write(0, 40, e);
      chk("b0_clamp_err", e, 0);
      for (int k = 0; k < 18; k++) begin
         sweep(-1, n, la, ld);
         exp_n = RAMP ? int'(k < 17) : int'(k == 0);
         exp_d = RAMP ? 18 + k : 34;
         chk("b0_nwrites", n, exp_n);
         if (exp_n == 1) begin
            chk("b0_addr", la, 0);
            chk("b0_data", ld, exp_d);
         end
      end

      // Illegal band
      host_write(12, 5, e);
      chk("bad_band_err", e, 1);
      @(negedge clk);
      chk("bad_band_err_drop", err, 0);
      sweep(-1, n, la, ld);
      chk("bad_band_nwrites", n, 0);

      // Overrun: second tick three cycles into the sweep
      host_write(5, 30, e);
      sweep(1, n, la, ld);
      chk("ovr_nwrites", n, 1);
      chk("ovr_addr", la, 5);
      chk("ovr_data", ld, RAMP ? 18 : 30);
      chk("ovr_set", overrun, 1);
      found = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (we) found++;
      end
      chk("ovr_no_extra_sweep", found, 0);
      chk("ovr_held", overrun, 1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", overrun, 0);

      // Reset in the middle of a sweep that writes
      host_write(8, 2, e);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      found = 0;
      for (int j = 0; j < 12 && found == 0; j++) begin
         @(negedge clk);
         if (we) found = 1;
      end
      chk("midsweep_write_seen", found, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_we", we, 0);
      chk("async_rst_busy", busy, 1);
      chk("async_rst_ready", hif.host_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      init_check();
      sweep(-1, n, la, ld);
      chk("targets_lost_nwrites", n, 0);

      // Band 9 -> 1
      host_write(9, 1, e);
      sweep(-1, n, la, ld);
      chk("b9_nwrites", n, 1);
      chk("b9_addr", la, 9);
      chk("b9_data", ld, RAMP ? 16 : 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
